// File: rtl/scan_config_loader.sv
// Host-side driver for a configuration scan chain: serialises host words LSB-first
// onto the chain and returns the bits shifted out of the tail as readback words.
//
// state   | meaning
// S_IDLE  | waiting for start
// S_LOAD  | waiting for the next host word
// S_SHIFT | shifting the buffered word onto the chain
// S_DRAIN | last bit issued; waiting for the final readback word to be accepted
// S_DONE  | one-cycle completion pulse
module scan_config_loader #(
  parameter int WORD_WIDTH   = 8,
  parameter int CHAIN_LENGTH = 32,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  scan_clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  chain_out,
  output logic                  chain_en,
  input  logic                  chain_in,
  output logic [WORD_WIDTH-1:0] rb_data,
  output logic                  rb_valid,
  input  logic                  rb_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int NWORDS    = (CHAIN_LENGTH + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int LAST_BITS = CHAIN_LENGTH - (NWORDS - 1) * WORD_WIDTH;
  localparam int WBW       = $clog2(WORD_WIDTH + 1);
  localparam int WCW       = $clog2(NWORDS + 1);

  localparam logic [CNT_WIDTH-1:0] LAST_BIT_IDX   = CNT_WIDTH'(CHAIN_LENGTH - 1);
  localparam logic [WCW-1:0]       LAST_WORD_IDX  = WCW'(NWORDS - 1);
  localparam logic [WBW-1:0]       FULL_WORD_BITS = WBW'(WORD_WIDTH);
  localparam logic [WBW-1:0]       TAIL_WORD_BITS = WBW'(LAST_BITS);
  localparam logic [WBW-1:0]       RB_LAST_POS    = WBW'(WORD_WIDTH - 1);
  localparam logic [WBW-1:0]       ONE_BIT        = WBW'(1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_DRAIN, S_DONE} state_t;

  state_t state, state_nxt;

  logic [WORD_WIDTH-1:0] shift_buf;
  logic [WBW-1:0]        word_bits;
  logic [CNT_WIDTH-1:0]  bit_cnt;
  logic [WCW-1:0]        word_cnt;
  logic [WORD_WIDTH-1:0] rb_acc;
  logic [WORD_WIDTH-1:0] rb_acc_nxt;
  logic [WBW-1:0]        rb_cnt;
  logic [CNT_WIDTH-1:0]  rb_total;

  logic stall, shift_go, word_take, load_start, rb_take, rb_last;

  assign stall      = rb_valid & ~rb_ready;
  assign shift_go   = (state == S_SHIFT) & ~stall;
  assign word_take  = (state == S_LOAD) & word_valid;
  assign load_start = (state == S_IDLE) & start;
  assign rb_take    = rb_valid & rb_ready;
  assign rb_last    = (rb_cnt == RB_LAST_POS) | (rb_total == LAST_BIT_IDX);
  assign rb_acc_nxt = rb_acc | (WORD_WIDTH'(chain_in) << rb_cnt);

  always_ff @(posedge scan_clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_LOAD;
      S_LOAD:  if (word_valid) state_nxt = S_SHIFT;
      S_SHIFT: if (shift_go && word_bits == ONE_BIT)
                 state_nxt = (bit_cnt == LAST_BIT_IDX) ? S_DRAIN : S_LOAD;
      // the final bit is still in flight while chain_en is high
      S_DRAIN: if (!chain_en && !rb_valid) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    word_ready = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      S_IDLE:  busy       = 1'b0;
      S_LOAD:  word_ready = 1'b1;
      S_DONE:  done       = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge scan_clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_en  <= 1'b0;
      chain_out <= 1'b0;
      shift_buf <= '0;
      word_bits <= '0;
      bit_cnt   <= '0;
      word_cnt  <= '0;
    end else begin
      chain_en  <= shift_go;
      chain_out <= shift_go & shift_buf[0];
      if (load_start) begin
        bit_cnt  <= '0;
        word_cnt <= '0;
      end
      if (word_take) begin
        shift_buf <= word_data;
        word_bits <= (word_cnt == LAST_WORD_IDX) ? TAIL_WORD_BITS : FULL_WORD_BITS;
        word_cnt  <= word_cnt + 1'b1;
      end
      if (shift_go) begin
        shift_buf <= shift_buf >> 1;
        word_bits <= word_bits - 1'b1;
        bit_cnt   <= bit_cnt + 1'b1;
      end
    end
  end

  // chain_in is valid on every edge where the chain itself shifts
  always_ff @(posedge scan_clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_acc   <= '0;
      rb_cnt   <= '0;
      rb_total <= '0;
      rb_data  <= '0;
      rb_valid <= 1'b0;
    end else begin
      if (load_start) begin
        rb_acc   <= '0;
        rb_cnt   <= '0;
        rb_total <= '0;
      end else if (chain_en) begin
        rb_total <= rb_total + 1'b1;
        if (rb_last) begin
          rb_data <= rb_acc_nxt;
          rb_acc  <= '0;
          rb_cnt  <= '0;
        end else begin
          rb_acc <= rb_acc_nxt;
          rb_cnt <= rb_cnt + 1'b1;
        end
      end
      if (chain_en && rb_last) rb_valid <= 1'b1;
      else if (rb_take)        rb_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_scan_config_loader.sv
// Bench for scan_config_loader: a 32-bit and a 20-bit chain instance, each driving a
// behavioural shift-register chain whose tail feeds back into chain_in.
module tb_scan_config_loader;

  logic scan_clk = 1'b0;
  always #5 scan_clk = ~scan_clk;

  logic       rst_n, start, word_valid, rb_ready, sel;
  logic [7:0] word_data;

  logic       word_ready_a, chain_out_a, chain_en_a, chain_in_a, rb_valid_a, busy_a, done_a;
  logic [7:0] rb_data_a;
  logic       word_ready_b, chain_out_b, chain_en_b, chain_in_b, rb_valid_b, busy_b, done_b;
  logic [7:0] rb_data_b;

  logic [31:0] chain_a = '0;
  logic [19:0] chain_b = '0;
  assign chain_in_a = chain_a[0];
  assign chain_in_b = chain_b[0];

  scan_config_loader #(.WORD_WIDTH(8), .CHAIN_LENGTH(32), .CNT_WIDTH(16)) dut_a (
    .scan_clk(scan_clk), .rst_n(rst_n), .start(start & ~sel),
    .word_data(word_data), .word_valid(word_valid & ~sel), .word_ready(word_ready_a),
    .chain_out(chain_out_a), .chain_en(chain_en_a), .chain_in(chain_in_a),
    .rb_data(rb_data_a), .rb_valid(rb_valid_a), .rb_ready(rb_ready),
    .busy(busy_a), .done(done_a));

  scan_config_loader #(.WORD_WIDTH(8), .CHAIN_LENGTH(20), .CNT_WIDTH(16)) dut_b (
    .scan_clk(scan_clk), .rst_n(rst_n), .start(start & sel),
    .word_data(word_data), .word_valid(word_valid & sel), .word_ready(word_ready_b),
    .chain_out(chain_out_b), .chain_en(chain_en_b), .chain_in(chain_in_b),
    .rb_data(rb_data_b), .rb_valid(rb_valid_b), .rb_ready(rb_ready),
    .busy(busy_b), .done(done_b));

  int         en_cnt_a = 0, done_cnt_a = 0, en_cnt_b = 0, done_cnt_b = 0;
  logic [7:0] rb_qa[$], rb_qb[$];
  logic       sh_qa[$], sh_qb[$];

  // chain models: bit 0 is the tail element feeding chain_in
  always @(posedge scan_clk) begin
    if (chain_en_a) begin
      chain_a <= {chain_out_a, chain_a[31:1]};
      en_cnt_a <= en_cnt_a + 1;
      sh_qa.push_back(chain_out_a);
    end
    if (done_a) done_cnt_a <= done_cnt_a + 1;
    if (rb_valid_a && rb_ready) rb_qa.push_back(rb_data_a);
  end

  always @(posedge scan_clk) begin
    if (chain_en_b) begin
      chain_b <= {chain_out_b, chain_b[19:1]};
      en_cnt_b <= en_cnt_b + 1;
      sh_qb.push_back(chain_out_b);
    end
    if (done_b) done_cnt_b <= done_cnt_b + 1;
    if (rb_valid_b && rb_ready) rb_qb.push_back(rb_data_b);
  end

  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int f_en();          return sel ? en_cnt_b : en_cnt_a;           endfunction
  function automatic int f_done();        return sel ? done_cnt_b : done_cnt_a;       endfunction
  function automatic int f_rbsize();      return sel ? rb_qb.size() : rb_qa.size();   endfunction
  function automatic int f_shsize();      return sel ? sh_qb.size() : sh_qa.size();   endfunction
  function automatic logic [7:0] f_rb(input int i); return sel ? rb_qb[i] : rb_qa[i]; endfunction
  function automatic logic f_sh(input int i);       return sel ? sh_qb[i] : sh_qa[i]; endfunction
  function automatic logic [31:0] f_chain(); return sel ? {12'b0, chain_b} : chain_a; endfunction
  function automatic logic f_ready();     return sel ? word_ready_b : word_ready_a;   endfunction
  function automatic logic f_chainen();   return sel ? chain_en_b : chain_en_a;       endfunction
  function automatic logic f_rbvalid();   return sel ? rb_valid_b : rb_valid_a;       endfunction
  function automatic logic [7:0] f_rbdata(); return sel ? rb_data_b : rb_data_a;      endfunction
  function automatic logic f_busy();      return sel ? busy_b : busy_a;               endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_chain_en"},   f_chainen(), 0);
    check({tag, "_chain_out"},  sel ? chain_out_b : chain_out_a, 0);
    check({tag, "_word_ready"}, f_ready(), 0);
    check({tag, "_rb_valid"},   f_rbvalid(), 0);
    check({tag, "_rb_data"},    f_rbdata(), 0);
    check({tag, "_busy"},       f_busy(), 0);
    check({tag, "_done"},       sel ? done_b : done_a, 0);
  endtask

  task automatic send_word(input logic [7:0] w);
    int t = 0;
    word_data  = w;
    word_valid = 1'b1;
    while (!f_ready() && t < 300) begin
      @(negedge scan_clk);
      t++;
    end
    if (t >= 300) check("word_ready_timeout", f_ready(), 1);
    @(negedge scan_clk);
    word_valid = 1'b0;
  endtask

  task automatic run_load(input string tag, input logic [3:0][7:0] w, input int nw,
                          input int len, input int gap_idx, input bit stall,
                          input logic [31:0] exp_chain, input logic [3:0][7:0] exp_rb,
                          input bit chk_rb);
    int en0, d0, rb0, sh0, t;
    logic [7:0] fb;
    en0 = f_en(); d0 = f_done(); rb0 = f_rbsize(); sh0 = f_shsize();
    @(negedge scan_clk) start = 1'b1;
    @(negedge scan_clk) start = 1'b0;
    fork
      begin
        for (int i = 0; i < nw; i++) begin
          if (i == gap_idx) begin
            int tg = 0;
            while (!f_ready() && tg < 300) begin
              @(negedge scan_clk);
              tg++;
            end
            @(negedge scan_clk);
            for (int k = 0; k < 5; k++) begin
              check($sformatf("%s_gap_chain_en_%0d", tag, k), f_chainen(), 0);
              @(negedge scan_clk);
            end
          end
          send_word(w[i]);
        end
      end
      begin
        if (stall) begin
          int ts = 0;
          logic [7:0] held;
          while (!f_rbvalid() && ts < 300) begin
            @(negedge scan_clk);
            ts++;
          end
          held = f_rbdata();
          rb_ready = 1'b0;
          for (int k = 0; k < 10; k++) begin
            @(negedge scan_clk);
            check($sformatf("%s_stall_chain_en_%0d", tag, k), f_chainen(), 0);
          end
          check({tag, "_stall_rb_valid"}, f_rbvalid(), 1);
          check({tag, "_stall_rb_data"}, f_rbdata(), held);
          rb_ready = 1'b1;
        end
      end
    join
    t = 0;
    while (f_done() - d0 < 1 && t < 500) begin
      @(negedge scan_clk);
      t++;
    end
    repeat (3) @(negedge scan_clk);
    check({tag, "_done_count"}, f_done() - d0, 1);
    check({tag, "_busy_after"}, f_busy(), 0);
    check({tag, "_en_count"}, f_en() - en0, len);
    check({tag, "_chain"}, f_chain(), exp_chain);
    for (int j = 0; j < 8; j++) fb[j] = f_sh(sh0 + j);
    check({tag, "_first_bits"}, fb, w[0]);
    if (chk_rb) begin
      check({tag, "_rb_count"}, f_rbsize() - rb0, nw);
      for (int i = 0; i < nw; i++)
        check($sformatf("%s_rb_word_%0d", tag, i), f_rb(rb0 + i), exp_rb[i]);
    end
  endtask

  typedef struct {
    logic [31:0] words;
    int          gap_idx;
    bit          stall;
    logic [31:0] exp_chain;
    logic [31:0] exp_rb;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int en0, t;
    vecs[0] = '{32'h0FF03CA5, -1, 1'b0, 32'h0FF03CA5, 32'h00000000};
    vecs[1] = '{32'h44332211, -1, 1'b0, 32'h44332211, 32'h0FF03CA5};
    vecs[2] = '{32'h00000000, -1, 1'b0, 32'h00000000, 32'h44332211};
    vecs[3] = '{32'hEFBEADDE,  2, 1'b0, 32'hEFBEADDE, 32'h00000000};
    vecs[4] = '{32'h78563412, -1, 1'b1, 32'h78563412, 32'hEFBEADDE};

    rst_n = 1'b0; start = 1'b0; word_valid = 1'b0; word_data = '0; rb_ready = 1'b1; sel = 1'b0;
    #12;
    check_idle_outputs("reset_a");
    sel = 1'b1;
    check_idle_outputs("reset_b");
    sel = 1'b0;
    @(negedge scan_clk) rst_n = 1'b1;
    @(negedge scan_clk);

    for (int v = 0; v < 5; v++)
      run_load($sformatf("vec%0d", v), vecs[v].words, 4, 32, vecs[v].gap_idx, vecs[v].stall,
               vecs[v].exp_chain, vecs[v].exp_rb, 1'b1);

    // reset in the middle of a load, then a clean full load
    en0 = en_cnt_a;
    @(negedge scan_clk) start = 1'b1;
    @(negedge scan_clk) start = 1'b0;
    send_word(8'h5A);
    send_word(8'hC3);
    t = 0;
    while (en_cnt_a - en0 < 10 && t < 300) begin
      @(negedge scan_clk);
      t++;
    end
    check("midreset_bits_before", en_cnt_a - en0, 10);
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("midreset");
    @(negedge scan_clk) rst_n = 1'b1;
    @(negedge scan_clk);
    run_load("after_reset", 32'h87654321, 4, 32, -1, 1'b0, 32'h87654321, '0, 1'b0);

    // 20-bit chain: only the low nibble of the third word is shifted
    sel = 1'b1;
    run_load("short_load1", 32'h00AFFFFF, 3, 20, -1, 1'b0, 32'h000FFFFF, 32'h00000000, 1'b1);
    run_load("short_load2", 32'h00000000, 3, 20, -1, 1'b0, 32'h00000000, 32'h000FFFFF, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
